// File: rtl/rc_pulse_conditioner_if.sv
// Pin-side and measurement-side signals of the RC pulse conditioner.
// The slave modport is the conditioner; the master modport is its environment.
interface rc_pulse_conditioner_if #(
  parameter int unsigned WIDTH_BITS = 12
);
  logic                  rc_pin_i;
  logic                  enable_o;
  logic                  pulse_valid_o;
  logic                  signal_lost_o;
  logic [WIDTH_BITS-1:0] pulse_width_o;
  logic                  pulse_strobe_o;

  modport master (
    output rc_pin_i,
    input  enable_o, pulse_valid_o, signal_lost_o, pulse_width_o, pulse_strobe_o
  );

  modport slave (
    input  rc_pin_i,
    output enable_o, pulse_valid_o, signal_lost_o, pulse_width_o, pulse_strobe_o
  );
endinterface

// File: rtl/rc_pulse_conditioner.sv
// RC receiver front end: synchronise and deglitch the pin, measure pulses,
// supervise frame rate and gate pulses to pwm_analyzer only while locked.
module rc_pulse_conditioner #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned FILTER_LEN    = 8,
  parameter int unsigned MIN_PULSE     = 800,
  parameter int unsigned MAX_PULSE     = 2200,
  parameter int unsigned FRAME_TIMEOUT = 25000,
  parameter int unsigned VALID_FRAMES  = 3,
  parameter int unsigned WIDTH_BITS    = 12
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  rc_pulse_conditioner_if.slave  bus
);

  localparam int unsigned FLT_W  = $clog2(FILTER_LEN + 1);
  localparam int unsigned FRM_W  = $clog2(FRAME_TIMEOUT + 1);
  localparam int unsigned GCNT_W = $clog2(VALID_FRAMES + 1);

  typedef enum logic [1:0] {S_LOST, S_ACQUIRE, S_LOCKED} state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_filt;
  logic [FLT_W-1:0]       r_fcnt;
  logic [WIDTH_BITS-1:0]  r_wcnt;
  logic [FRM_W-1:0]       r_frm;
  state_t                 r_state;
  logic [GCNT_W-1:0]      r_gcnt;
  logic                   r_gate;
  logic                   r_enable;
  logic                   r_valid;
  logic                   r_lost;
  logic                   r_strobe;
  logic [WIDTH_BITS-1:0]  r_width;

  logic w_sync, w_take, w_rise, w_fall, w_good, w_sat, w_timeout, w_leave_locked;

  // Edges are decoded in the cycle before filt changes so all reactions share that edge.
  assign w_sync         = r_sync[SYNC_STAGES-1];
  assign w_take         = (w_sync != r_filt) && (r_fcnt == FLT_W'(FILTER_LEN - 1));
  assign w_rise         = w_take &  w_sync;
  assign w_fall         = w_take & ~w_sync;
  assign w_good         = (r_wcnt >= WIDTH_BITS'(MIN_PULSE)) && (r_wcnt <= WIDTH_BITS'(MAX_PULSE));
  assign w_sat          = r_filt && !w_fall && (r_wcnt == WIDTH_BITS'(MAX_PULSE));
  assign w_timeout      = !w_rise && (r_frm >= FRM_W'(FRAME_TIMEOUT - 1));
  assign w_leave_locked = (r_state == S_LOCKED) && (w_timeout || w_sat || (w_fall && !w_good));

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) r_sync <= '0;
    else         r_sync <= {r_sync[SYNC_STAGES-2:0], bus.rc_pin_i};
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_filt <= 1'b0;
      r_fcnt <= '0;
    end else if (w_sync == r_filt) begin
      r_fcnt <= '0;
    end else if (w_take) begin
      r_filt <= w_sync;
      r_fcnt <= '0;
    end else begin
      r_fcnt <= r_fcnt + FLT_W'(1);
    end
  end

  // Width count includes the cycle in which filt rises, so it equals high time at fall.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_wcnt   <= '0;
      r_width  <= '0;
      r_strobe <= 1'b0;
    end else begin
      r_strobe <= 1'b0;
      if (w_rise)
        r_wcnt <= WIDTH_BITS'(1);
      else if (r_filt && !w_fall && (r_wcnt != WIDTH_BITS'(MAX_PULSE + 1)))
        r_wcnt <= r_wcnt + WIDTH_BITS'(1);
      if (w_fall) begin
        r_width  <= r_wcnt;
        r_strobe <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i)                             r_frm <= '0;
    else if (w_rise)                         r_frm <= '0;
    else if (r_frm != FRM_W'(FRAME_TIMEOUT)) r_frm <= r_frm + FRM_W'(1);
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= S_LOST;
      r_gcnt  <= '0;
      r_valid <= 1'b0;
      r_lost  <= 1'b1;
    end else begin
      case (r_state)
        S_LOST: begin
          r_gcnt <= '0;
          if (w_rise) begin
            r_state <= S_ACQUIRE;
            r_lost  <= 1'b0;
          end
        end
        S_ACQUIRE: begin
          if (w_timeout) begin
            r_state <= S_LOST;
            r_lost  <= 1'b1;
            r_gcnt  <= '0;
          end else if (w_fall) begin
            if (!w_good) begin
              r_gcnt <= '0;
            end else if (r_gcnt == GCNT_W'(VALID_FRAMES - 1)) begin
              r_state <= S_LOCKED;
              r_valid <= 1'b1;
              r_gcnt  <= '0;
            end else begin
              r_gcnt <= r_gcnt + GCNT_W'(1);
            end
          end
        end
        S_LOCKED: begin
          if (w_timeout) begin
            r_state <= S_LOST;
            r_lost  <= 1'b1;
            r_valid <= 1'b0;
            r_gcnt  <= '0;
          end else if (w_sat || (w_fall && !w_good)) begin
            r_state <= S_ACQUIRE;
            r_valid <= 1'b0;
            r_gcnt  <= '0;
          end
        end
        default: r_state <= S_LOST;
      endcase
    end
  end

  // Gate only opens at a rise seen while locked, so partial pulses never leak out.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_gate   <= 1'b0;
      r_enable <= 1'b0;
    end else begin
      if (w_fall || w_leave_locked)
        r_gate <= 1'b0;
      else if (w_rise && (r_state == S_LOCKED))
        r_gate <= 1'b1;
      r_enable <= r_filt & r_gate;
    end
  end

  assign bus.enable_o       = r_enable;
  assign bus.pulse_valid_o  = r_valid;
  assign bus.signal_lost_o  = r_lost;
  assign bus.pulse_width_o  = r_width;
  assign bus.pulse_strobe_o = r_strobe;

endmodule

// File: doc/rc_pulse_conditioner.md
# rc_pulse_conditioner

- Front-end stage for an RC receiver PWM input. It sits directly upstream of `pwm_analyzer` and drives that block's `enable_i`.
- Synchronises the raw asynchronous receiver pin and removes glitches shorter than a programmable length.
- Measures every pulse and supervises the frame rate.
- Passes pulses downstream only after link lock, and reports link loss so the system can enter failsafe.

## Interface

Parameters:
- `SYNC_STAGES`, 2: synchroniser flop count (≥2).
- `FILTER_LEN`, 8: consecutive stable cycles needed to accept a level change.
- `MIN_PULSE`, 800: shortest good pulse, in cycles.
- `MAX_PULSE`, 2200: longest good pulse, in cycles.
- `FRAME_TIMEOUT`, 25000: cycles without a rising edge before the link is declared lost.
- `VALID_FRAMES`, 3: consecutive good pulses required to lock.
- `WIDTH_BITS`, 12: width of `pulse_width_o`. Must hold `MAX_PULSE+1`.

Ports:
- `clock_i` in 1: single system clock (1 MHz, so 1 cycle = 1 µs).
- `reset_i` in 1: reset, asynchronous, active-high.
- `rc_pin_i` in 1: raw receiver pin, asynchronous to `clock_i`.
- `enable_o` out 1: conditioned pulse; connects to `pwm_analyzer.enable_i`.
- `pulse_valid_o` out 1: high while the link is locked.
- `signal_lost_o` out 1: high while no frames are arriving.
- `pulse_width_o` out WIDTH_BITS: width of the last completed pulse, saturating.
- `pulse_strobe_o` out 1: one-cycle pulse when `pulse_width_o` updates.

## Operation

**Reset.** Asynchronous, active-high; every flop clears. While `reset_i` is asserted and after release:
- `enable_o` = 0, `pulse_valid_o` = 0, `signal_lost_o` = 1, `pulse_width_o` = 0, `pulse_strobe_o` = 0.
- State = LOST; synchroniser and filter = 0.

**Input conditioning.**
- Synchroniser: `SYNC_STAGES` flops.
- Filter: output `filt` takes the synchronised level only after that level has differed from `filt` for `FILTER_LEN` consecutive cycles. Any shorter excursion resets the stability counter.
- Edge detect on `filt`: `rise` and `fall`.

**Width counter.**
- Cleared on `rise`; increments while `filt` = 1.
- Saturates at `MAX_PULSE+1`.
- On `fall`: `pulse_width_o` takes the count and `pulse_strobe_o` pulses.
- Good pulse: `MIN_PULSE` ≤ width ≤ `MAX_PULSE`; otherwise bad.

**Frame counter.**
- Cleared on `rise`; otherwise increments, saturating at `FRAME_TIMEOUT`.
- Timeout = counter reaches `FRAME_TIMEOUT`.
- `rise` in the same cycle as a would-be timeout wins: no timeout.

**State machine** (good-pulse count `gcnt`):
- LOST: `signal_lost_o` = 1, `gcnt` = 0. First `rise` → ACQUIRE.
- ACQUIRE: `signal_lost_o` = 0, `pulse_valid_o` = 0.
  - Good `fall` increments `gcnt`; bad `fall` clears it.
  - `gcnt` reaching `VALID_FRAMES` → LOCKED, at the completing `fall`.
- LOCKED: `pulse_valid_o` = 1.
  - Bad `fall` → ACQUIRE, `gcnt` = 0.
  - Width reaching `MAX_PULSE+1` → ACQUIRE immediately, `gcnt` = 0.
- Timeout in any state → LOST.

**Pass gate.**
- Set on a `rise` while LOCKED.
- Cleared on `fall`, on leaving LOCKED, and on reset.
- `enable_o` = registered (`filt` AND pass gate).
- A pulse that begins outside LOCKED never reaches `enable_o`, even if lock is gained during it.
- Over-long pulse: `enable_o` stays high for exactly `MAX_PULSE` cycles, then drops.
- Short bad pulse: passed in full, because badness is known only at `fall`.

## Timing

- Latency L = `SYNC_STAGES` + `FILTER_LEN` + 1 cycles (11 at defaults), identical on both edges. Passed pulse width is preserved exactly.
- `pulse_strobe_o` and `pulse_width_o` update L−1 cycles after the raw falling edge.
- `pulse_valid_o` rises on that same cycle for the locking pulse.
- `pulse_valid_o` falls on the same cycle as a bad `fall`, or as the width reaching saturation.
- `signal_lost_o` rises `FRAME_TIMEOUT` cycles after the last `rise`, and falls the cycle after the next `rise`.
- Reset asserted mid-pulse: all outputs go to reset values immediately; the next pulse must wait for the filter before it can be counted.

## Test plan

1. Reset, `rc_pin_i` = 0 for 30000 cycles → `signal_lost_o` = 1, `enable_o` = 0, `pulse_valid_o` = 0, `pulse_width_o` = 0 throughout.
2. Four 1500-cycle pulses at a 20000-cycle period:
   - `pulse_width_o` = 1500 with a strobe after each pulse.
   - `pulse_valid_o` rises at the third `fall`.
   - Only the fourth pulse appears on `enable_o`: 1500 cycles high, delayed 11 cycles.
3. Locked; inject 5-cycle spikes into the low phase and 5-cycle dropouts into a 1900-cycle pulse → no `enable_o` change, `pulse_width_o` = 1900, lock kept.
4. Locked; one 2500-cycle pulse → `enable_o` high exactly 2200 cycles, `pulse_valid_o` falls at that cycle, `pulse_width_o` = 2201. The next three 1000-cycle pulses relock, and the fifth pulse passes.
5. Locked; one 500-cycle pulse → passed on `enable_o` (500 cycles), `pulse_width_o` = 500, `pulse_valid_o` drops at its `fall`.
6. Locked; input held low → `signal_lost_o` = 1 exactly 25000 cycles after the last `rise`. Then assert reset mid-pulse → `enable_o` = 0 immediately, state LOST.
